// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Returns {remainder, quotient}; divide-by-zero yields all zeros.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divider_i,
  input  logic                  start_i,
  input  logic                  cancel_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  success_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned WRK_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WRK_W-1:0]    work_q, work_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic [WRK_W-1:0]    result_q, result_d;
  logic                success_q, success_d;

  logic [DATA_W:0]     diff;
  logic [WRK_W-1:0]    work_iter;
  logic [DATA_W-1:0]   a_abs, b_abs, q_fin, r_fin;

  assign result_o  = result_q;
  assign success_o = success_q;

  // Synchronous reset; all architectural state registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      result_q  <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      dvsr_q    <= dvsr_d;
      cnt_q     <= cnt_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      result_q  <= result_d;
      success_q <= success_d;
    end
  end

  // Datapath: one restoring step, operand magnitudes and signed fix-up.
  // The partial remainder lives in work[63:32]; quotient bits shift in at the LSB.
  always_comb begin
    diff      = work_q[WRK_W-1:DATA_W-1] - {1'b0, dvsr_q};
    work_iter = diff[DATA_W] ? {work_q[WRK_W-2:0], 1'b0}
                             : {diff[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};
    q_fin     = negq_q ? -work_iter[DATA_W-1:0] : work_iter[DATA_W-1:0];
    r_fin     = negr_q ? -work_iter[WRK_W-1:DATA_W] : work_iter[WRK_W-1:DATA_W];
    a_abs     = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
    b_abs     = (signed_i && divider_i[DATA_W-1])  ? -divider_i  : divider_i;
  end

  // Next-state and register updates; cancel overrides everything.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    result_d  = result_q;
    success_d = success_q;
    if (cancel_i) begin
      state_d   = IDLE;
      success_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (divider_i == '0) begin
              state_d = BYZERO;
            end else begin
              state_d = ON;
              work_d  = {DATA_W'(0), a_abs};
              dvsr_d  = b_abs;
              cnt_d   = '0;
              negq_d  = signed_i & (dividend_i[DATA_W-1] ^ divider_i[DATA_W-1]);
              negr_d  = signed_i & dividend_i[DATA_W-1];
            end
          end
        end
        BYZERO: begin
          if (!start_i) begin
            state_d = IDLE;
          end else begin
            state_d   = END;
            result_d  = '0;
            success_d = 1'b1;
          end
        end
        ON: begin
          if (!start_i) begin
            state_d = IDLE;
          end else begin
            work_d = work_iter;
            cnt_d  = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_d   = END;
              result_d  = {r_fin, q_fin};
              success_d = 1'b1;
            end
          end
        end
        END: begin
          if (!start_i) begin
            state_d   = IDLE;
            success_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with a 64-bit arithmetic reference.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divider_i;
  logic        start_i;
  logic        cancel_i;
  logic [63:0] result_o;
  logic        success_o;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic        succ_prev = 1'b0;
  logic [63:0] mon_e;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divider_i  (divider_i),
    .start_i    (start_i),
    .cancel_i   (cancel_i),
    .result_o   (result_o),
    .success_o  (success_o)
  );

  always #5 clk = ~clk;

  // Reference: exact 64-bit integer division (truncating, remainder follows dividend).
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every new success pops one expected result.
  always @(negedge clk) begin
    if (success_o && !succ_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_success: got result %h with nothing expected", result_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", result_o, mon_e);
      end
    end
    succ_prev = success_o;
  end

  // Issue one division (called just after a rising edge), hold, then release.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] e;
    int k;
    int lat;
    e = model(s, a, b);
    exp_q.push_back(e);
    signed_i   = s;
    dividend_i = a;
    divider_i  = b;
    start_i    = 1'b1;
    lat = (b == 32'd0) ? 2 : 33;
    k = 0;
    while (k < 45) begin
      @(posedge clk); #1;
      k++;
      if (success_o) break;
    end
    check("latency", 64'(k), 64'(lat));
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_result", result_o, e);
      check("hold_success", 64'(success_o), 64'd1);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check("success_drop", 64'(success_o), 64'd0);
  endtask

  // Count success cycles over a window where none is expected.
  task automatic expect_quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (success_o) hits++;
    end
    check(name, 64'(hits), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        s;
    logic [31:0] a, b;
    rst        = 1'b1;
    signed_i   = 1'b0;
    dividend_i = '0;
    divider_i  = '0;
    start_i    = 1'b0;
    cancel_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_success", 64'(success_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op(1'b0, 32'd100, 32'd7, 2);
    check("udiv_100_7", result_o, {32'd2, 32'd14});
    do_op(1'b1, 32'hFFFFFFF9, 32'h2, 0);
    check("sdiv_m7_2", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    check("sdiv_7_m2", result_o, {32'h00000001, 32'hFFFFFFFD});
    do_op(1'b0, 32'hFFFFFFFF, 32'h10, 1);
    check("udiv_max_16", result_o, {32'hF, 32'h0FFFFFFF});
    do_op(1'b0, 32'd5, 32'd0, 1);
    check("div_by_zero", result_o, 64'd0);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    check("sdiv_min_m1", result_o, {32'h0, 32'h80000000});

    // Cancel mid-division while start is still high
    signed_i = 1'b0; dividend_i = 32'd100; divider_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    start_i  = 1'b0;
    check("cancel_success", 64'(success_o), 64'd0);
    check("cancel_keeps_result", result_o, {32'h0, 32'h80000000});
    expect_quiet("cancel_quiet", 40);
    do_op(1'b0, 32'd100, 32'd7, 0);

    // Dropping start mid-division abandons it
    start_i = 1'b1; dividend_i = 32'd1000; divider_i = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    start_i = 1'b0;
    expect_quiet("start_drop_quiet", 40);

    // Synchronous reset mid-division
    start_i = 1'b1; dividend_i = 32'd100; divider_i = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_result", result_o, 64'd0);
    check("midrst_success", 64'(success_o), 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;

    // Held start does not restart; then back-to-back with a one-cycle gap
    do_op(1'b0, 32'd50, 32'd6, 5);
    do_op(1'b0, 32'd9, 32'd3, 0);
    check("udiv_9_3", result_o, {32'd0, 32'd3});

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_op(s, a, b, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
